// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_RW byte-strobed control registers followed by NUM_RO status registers.
// Write response one cycle after the later AW/W handshake, read data one cycle after AR.
module axi_lite_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    NUM_RW      = 8,
    parameter int                    NUM_RO      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                          S_AXI_ACLK,
    input  logic                                          S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                       S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                         S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                  reg_out,
    output logic [NUM_RW-1:0]                             wr_pulse,
    // One dummy slice keeps the port legal when NUM_RO is zero.
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] sts_in
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    logic [NUM_RW-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  unused_bits;

    assign aw_hs   = S_AXI_AWVALID & awready_q;
    assign w_hs    = S_AXI_WVALID & wready_q;
    assign ar_hs   = S_AXI_ARVALID & arready_q;
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        regs_d     = regs_q;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Commit on the edge that completes the address/data pair, whichever came last.
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = 2'b11;
            for (int k = 0; k < NUM_RW; k++) begin
                if (int'(wr_idx) == k) begin
                    bresp_d       = 2'b00;
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if (int'(wr_idx) == NUM_RW + k) bresp_d = 2'b10;
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
        end

        // Reads see regs_q, so a same-edge write is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 2'b11;
            for (int k = 0; k < NUM_RW; k++) begin
                if (int'(rd_idx) == k) begin
                    rdata_d = regs_q[k];
                    rresp_d = 2'b00;
                end
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if (int'(rd_idx) == NUM_RW + k) begin
                    rdata_d = sts_in[k*DATA_WIDTH +: DATA_WIDTH];
                    rresp_d = 2'b00;
                end
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            regs_q     <= {NUM_RW{RESET_VALUE}};
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_out       = regs_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboarded bench for axi_lite_regfile: directed scenarios plus random single transactions.
module tb_axi_lite_regfile;
    localparam int          NRW = 8;
    localparam int          NRO = 4;
    localparam logic [31:0] RV  = 32'hA5A5_1234;

    typedef struct { logic [1:0] resp; logic [7:0] pulse; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic [127:0] sts;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_rise_cyc = -1, r_rise_cyc = -1;
    int last_w_hs, last_r_hs, last_aw_hs, last_wd_hs;
    logic [31:0] mdl [NRW];
    bexp_t exp_b [$];
    rexp_t exp_r [$];
    bexp_t be;
    rexp_t re;
    logic bv_prev = 1'b0, rv_prev = 1'b0;

    axi_lite_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_RW(NRW), .NUM_RO(NRO),
                       .RESET_VALUE(RV)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .sts_in(sts));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: address index = byte address / 4, first NRW are RW, next NRO are RO.
    task automatic exp_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        bexp_t e;
        idx = int'(a) / 4;
        e.pulse = 8'h00;
        if (idx < NRW) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            e.resp  = 2'b00;
            e.pulse = 8'(1 << idx);
        end else if (idx < NRW + NRO) begin
            e.resp = 2'b10;
        end else begin
            e.resp = 2'b11;
        end
        exp_b.push_back(e);
    endtask

    task automatic exp_read(input logic [5:0] a);
        int idx;
        rexp_t e;
        idx = int'(a) / 4;
        if (idx < NRW) begin
            e.data = mdl[idx];  e.resp = 2'b00;
        end else if (idx < NRW + NRO) begin
            e.data = sts[(idx-NRW)*32 +: 32];  e.resp = 2'b00;
        end else begin
            e.data = 32'h0;  e.resp = 2'b11;
        end
        exp_r.push_back(e);
    endtask

    task automatic drive_aw(input logic [5:0] a, input int dly, output int hs);
        repeat (dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1; hs = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready) begin hs = cyc + 1; break; end
        end
        @(posedge clk); #1; awvalid = 1'b0;
        if (hs < 0) chk("aw_handshake_timeout", 1, 0);
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
        repeat (dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1; hs = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wready) begin hs = cyc + 1; break; end
        end
        @(posedge clk); #1; wvalid = 1'b0;
        if (hs < 0) chk("w_handshake_timeout", 1, 0);
    endtask

    task automatic drive_read(input logic [5:0] a);
        int hs;
        araddr = a; arvalid = 1'b1; hs = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) begin hs = cyc + 1; break; end
        end
        @(posedge clk); #1; arvalid = 1'b0;
        if (hs < 0) chk("ar_handshake_timeout", 1, 0);
        last_r_hs = hs;
    endtask

    task automatic drive_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int daw, input int dw);
        int h1, h2;
        fork
            drive_aw(a, daw, h1);
            drive_w(d, s, dw, h2);
        join
        last_aw_hs = h1;
        last_wd_hs = h2;
        last_w_hs  = (h1 > h2) ? h1 : h2;
    endtask

    task automatic wait_b();
        for (int n = 0; n < 60 && exp_b.size() != 0; n++) begin @(posedge clk); #2; end
        if (exp_b.size() != 0) chk("b_response_timeout", 64'(exp_b.size()), 0);
        else chk("b_latency", 64'(b_rise_cyc), 64'(last_w_hs));
    endtask

    task automatic wait_r();
        for (int n = 0; n < 60 && exp_r.size() != 0; n++) begin @(posedge clk); #2; end
        if (exp_r.size() != 0) chk("r_response_timeout", 64'(exp_r.size()), 0);
        else chk("r_latency", 64'(r_rise_cyc), 64'(last_r_hs));
    endtask

    task automatic check_regs();
        for (int k = 0; k < NRW; k++) chk("reg_out", reg_out[k*32 +: 32], mdl[k]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_awready", awready, 0);  chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);  chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);    chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_bresp", bresp, 0);      chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        check_regs();
    endtask

    task automatic release_reset();
        @(posedge clk); #1; areset = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_first_edge", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
    endtask

    // Monitor: pops expectations on each B/R handshake and checks write strobes on BVALID rise.
    always @(negedge clk) begin
        if (areset) begin
            bv_prev = 1'b0; rv_prev = 1'b0;
        end else begin
            if (bvalid && !bv_prev) begin
                b_rise_cyc = cyc;
                if (exp_b.size() > 0) chk("wr_pulse", wr_pulse, exp_b[0].pulse);
            end else if (wr_pulse != 8'h00) begin
                chk("wr_pulse_spurious", wr_pulse, 0);
            end
            if (rvalid && !rv_prev) r_rise_cyc = cyc;
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("unexpected_b", 1, 0);
                else begin be = exp_b.pop_front(); chk("bresp", bresp, be.resp); end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("unexpected_r", 1, 0);
                else begin
                    re = exp_r.pop_front();
                    chk("rdata", rdata, re.data);
                    chk("rresp", rresp, re.resp);
                end
            end
            bv_prev = bvalid;
            rv_prev = rvalid;
        end
    end

    initial begin
        int h;
        logic [5:0]  a;
        logic [31:0] d;
        awaddr = '0; awprot = 3'b010; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        araddr = '0; arprot = 3'b101; arvalid = 0; bready = 1; rready = 1;
        sts = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
        for (int k = 0; k < NRW; k++) mdl[k] = RV;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        release_reset();

        for (int i = 0; i < 4; i++) begin
            exp_write(6'(4*i), 32'(i+1), 4'hF);
            drive_write(6'(4*i), 32'(i+1), 4'hF, 0, 0);
            wait_b();
        end
        for (int i = 0; i < 4; i++) begin
            exp_read(6'(4*i)); drive_read(6'(4*i)); wait_r();
        end
        check_regs();

        exp_write(6'h00, 32'hAABBCCDD, 4'hF); drive_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0); wait_b();
        exp_write(6'h00, 32'h11223344, 4'h5); drive_write(6'h00, 32'h11223344, 4'h5, 0, 0); wait_b();
        exp_read(6'h00); drive_read(6'h00); wait_r();
        chk("strobe_merge", reg_out[31:0], 32'hAA22CC44);

        exp_write(6'h10, 32'h0BADF00D, 4'hF); drive_write(6'h10, 32'h0BADF00D, 4'hF, 3, 0); wait_b();
        chk("w_before_aw_gap", 64'(last_aw_hs - last_wd_hs), 3);
        exp_write(6'h14, 32'h600DCAFE, 4'hF); drive_write(6'h14, 32'h600DCAFE, 4'hF, 0, 0); wait_b();
        chk("aw_w_same_edge", 64'(last_aw_hs), 64'(last_wd_hs));

        exp_read(6'h20); drive_read(6'h20); wait_r();
        exp_write(6'h20, 32'h12345678, 4'hF); drive_write(6'h20, 32'h12345678, 4'hF, 0, 0); wait_b();
        exp_read(6'h30); drive_read(6'h30); wait_r();
        exp_write(6'h30, 32'h87654321, 4'hF); drive_write(6'h30, 32'h87654321, 4'hF, 0, 0); wait_b();
        check_regs();

        repeat (2) begin @(posedge clk); #1; end
        exp_read(6'h14);
        exp_write(6'h14, 32'hFEEDFACE, 4'hF);
        fork
            drive_write(6'h14, 32'hFEEDFACE, 4'hF, 0, 0);
            drive_read(6'h14);
        join
        chk("raw_same_edge", 64'(last_r_hs), 64'(last_w_hs));
        wait_b(); wait_r();

        repeat (2) begin @(posedge clk); #1; end
        bready = 0; rready = 0;
        exp_write(6'h08, 32'hC0FFEE00, 4'hF);
        exp_read(6'h0C);
        fork
            drive_write(6'h08, 32'hC0FFEE00, 4'hF, 0, 0);
            drive_read(6'h0C);
        join
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1);             chk("bp_bresp", bresp, exp_b[0].resp);
            chk("bp_rvalid", rvalid, 1);             chk("bp_rdata", rdata, exp_r[0].data);
            chk("bp_rresp", rresp, exp_r[0].resp);   chk("bp_readies", {awready, wready, arready}, 0);
        end
        @(posedge clk); #1; bready = 1; rready = 1;
        wait_b(); wait_r();

        for (int i = 0; i < 40; i++) begin
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                h = $urandom_range(0, 15);
                exp_write(a, d, 4'(h));
                drive_write(a, d, 4'(h), $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b();
            end else begin
                exp_read(a); drive_read(a); wait_r();
            end
        end
        check_regs();

        rready = 0;
        drive_read(6'h04);
        drive_aw(6'h08, 0, h);
        areset = 1'b1;
        exp_b.delete(); exp_r.delete();
        for (int k = 0; k < NRW; k++) mdl[k] = RV;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rready = 1;
        release_reset();
        drive_w(32'h13579BDF, 4'hF, 0, h);
        repeat (3) @(negedge clk);
        chk("dropped_aw_no_b", bvalid, 0);
        check_regs();
        @(posedge clk); #1;
        exp_write(6'h08, 32'h13579BDF, 4'hF);
        drive_aw(6'h08, 0, h);
        last_w_hs = h;
        wait_b();
        check_regs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
